// File: rtl/ahblite_busmatrix_arbiter_rr_pkg.sv
// Shared definitions for the AHB-Lite bus-matrix output-stage arbiter and
// the other multi-master slave ports: transfer/burst codes, FSM states, beat count.
package ahblite_busmatrix_arbiter_rr_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   typedef enum logic [1:0] {
      ST_ARB        = 2'b00,
      ST_HOLD_FIXED = 2'b01,
      ST_HOLD_INCR  = 2'b10
   } arb_state_e;

   // Fixed-length bursts report their beat count; SINGLE/INCR report one beat.
   function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
      logic [4:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
         default:                      beats = 5'd1;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahblite_busmatrix_arbiter_rr_pick.sv
// Combinational round-robin winner search: first requester after last_grant_i,
// wrapping modulo NUM_PORTS. Module ahblite_rr_pick, shared by several slave ports.
module ahblite_rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 2
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [PORT_W-1:0]    last_grant_i,
   output logic [PORT_W-1:0]    winner_o,
   output logic                 any_req_o
);

   // Walk candidates from farthest to nearest so the nearest requester wins.
   always_comb begin
      int cand;
      cand      = 0;
      winner_o  = '0;
      any_req_o = 1'b0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = (int'(last_grant_i) + k) % NUM_PORTS;
         if (req_i[cand[PORT_W-1:0]]) begin
            winner_o  = cand[PORT_W-1:0];
            any_req_o = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// Round-robin arbiter for one AHB-Lite bus-matrix output stage. Burst hold
// (fixed and INCR) is built only with AHB_ARB_BURST_LOCK_EN; HMASTLOCK hold always.
module ahblite_busmatrix_arbiter_rr
   import ahblite_busmatrix_arbiter_rr_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 2
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] REQ,
   input  logic                 HREADY_Outputstage,
   input  logic                 HSEL_Outputstage,
   input  logic [1:0]           HTRANS_Outputstage,
   input  logic [2:0]           HBURST_Outputstage,
   input  logic                 HMASTLOCK_Outputstage,
   output logic [PORT_W-1:0]    PORT_SEL_ARBITER,
   output logic                 PORT_NOSEL_ARBITER
);

   localparam logic [PORT_W-1:0] LAST_RST = PORT_W'(NUM_PORTS - 1);

   logic [PORT_W-1:0] sel_q, sel_d;
   logic [PORT_W-1:0] last_q, last_d;
   logic              nosel_q, nosel_d;
   logic [PORT_W-1:0] winner_s;
   logic              any_req_s;
   logic              do_arb_s;

   ahblite_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_pick (
      .req_i        (REQ),
      .last_grant_i (last_q),
      .winner_o     (winner_s),
      .any_req_o    (any_req_s)
   );

`ifdef AHB_ARB_BURST_LOCK_EN
   arb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Burst-hold FSM and counter; a locked cycle freezes them together with the grant.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      do_arb_s = 1'b0;
      if (HMASTLOCK_Outputstage) begin
         do_arb_s = 1'b0;
      end else begin
         case (state_q)
            ST_ARB: begin
               if (HTRANS_Outputstage == HTRANS_NONSEQ && HBURST_Outputstage == HBURST_INCR) begin
                  state_d = ST_HOLD_INCR;
               end else if (HTRANS_Outputstage == HTRANS_NONSEQ && HBURST_Outputstage != HBURST_SINGLE) begin
                  state_d = ST_HOLD_FIXED;
                  cnt_d   = 4'(burst_beats(HBURST_Outputstage) - 5'd1);
               end else begin
                  do_arb_s = 1'b1;
               end
            end
            ST_HOLD_FIXED: begin
               case (HTRANS_Outputstage)
                  HTRANS_SEQ: begin
                     if (cnt_q <= 4'd1) begin
                        state_d = ST_ARB;
                        cnt_d   = 4'd0;
                     end else begin
                        cnt_d   = cnt_q - 4'd1;
                     end
                  end
                  HTRANS_BUSY: begin
                     cnt_d = cnt_q;
                  end
                  default: begin
                     state_d = ST_ARB;
                     cnt_d   = 4'd0;
                  end
               endcase
            end
            ST_HOLD_INCR: begin
               if (HTRANS_Outputstage == HTRANS_IDLE || HTRANS_Outputstage == HTRANS_NONSEQ) begin
                  state_d = ST_ARB;
               end else begin
                  state_d = ST_HOLD_INCR;
               end
            end
            default: begin
               state_d = ST_ARB;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   // Burst-hold state registers, frozen while the slave stalls.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_ARB;
         cnt_q   <= 4'd0;
      end else if (HREADY_Outputstage) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   logic unused_hburst_s;
   assign unused_hburst_s = ^HBURST_Outputstage;

   // Without burst hold, only SEQ/BUSY beats and locked cycles keep the grant.
   always_comb begin
      do_arb_s = ~HMASTLOCK_Outputstage
               & (HTRANS_Outputstage != HTRANS_SEQ)
               & (HTRANS_Outputstage != HTRANS_BUSY);
   end
`endif

   // Grant decision; with no requester, an in-flight slave selection keeps NOSEL low.
   always_comb begin
      sel_d   = sel_q;
      last_d  = last_q;
      nosel_d = nosel_q;
      if (do_arb_s) begin
         if (any_req_s) begin
            sel_d   = winner_s;
            last_d  = winner_s;
            nosel_d = 1'b0;
         end else if (HSEL_Outputstage) begin
            nosel_d = 1'b0;
         end else begin
            nosel_d = 1'b1;
         end
      end else begin
         nosel_d = nosel_q;
      end
   end

   // Grant registers, frozen while the slave stalls.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q   <= '0;
         last_q  <= LAST_RST;
         nosel_q <= 1'b1;
      end else if (HREADY_Outputstage) begin
         sel_q   <= sel_d;
         last_q  <= last_d;
         nosel_q <= nosel_d;
      end
   end

   assign PORT_SEL_ARBITER   = sel_q;
   assign PORT_NOSEL_ARBITER = nosel_q;

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_rr.sv
// Self-checking bench for ahblite_busmatrix_arbiter_rr: directed scenarios plus
// random traffic against a transaction-level grant model (honours AHB_ARB_BURST_LOCK_EN).
module tb_ahblite_busmatrix_arbiter_rr;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
   localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_WRAP16 = 3'd6;

   logic       HCLK;
   logic       HRESETn;
   logic [3:0] REQ;
   logic       HREADY_Outputstage;
   logic       HSEL_Outputstage;
   logic [1:0] HTRANS_Outputstage;
   logic [2:0] HBURST_Outputstage;
   logic       HMASTLOCK_Outputstage;
   logic [1:0] PORT_SEL_ARBITER;
   logic       PORT_NOSEL_ARBITER;

   int n_cmp = 0;
   int n_err = 0;

   // model state: current owner, idle flag, last winner, hold mode (0 none, 1 fixed, 2 incr)
   int m_owner, m_last, m_mode, m_left;
   bit m_idle;

   ahblite_busmatrix_arbiter_rr #(.NUM_PORTS(4), .PORT_W(2)) dut (
      .HCLK                  (HCLK),
      .HRESETn               (HRESETn),
      .REQ                   (REQ),
      .HREADY_Outputstage    (HREADY_Outputstage),
      .HSEL_Outputstage      (HSEL_Outputstage),
      .HTRANS_Outputstage    (HTRANS_Outputstage),
      .HBURST_Outputstage    (HBURST_Outputstage),
      .HMASTLOCK_Outputstage (HMASTLOCK_Outputstage),
      .PORT_SEL_ARBITER      (PORT_SEL_ARBITER),
      .PORT_NOSEL_ARBITER    (PORT_NOSEL_ARBITER)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] req, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (req[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = 0; m_last = 3; m_mode = 0; m_left = 0; m_idle = 1'b1;
   endtask

   task automatic model_step();
      bit rearb;
      int w;
      if (!HREADY_Outputstage || HMASTLOCK_Outputstage) return;
`ifdef AHB_ARB_BURST_LOCK_EN
      rearb = 1'b0;
      if (m_mode == 0) begin
         if (HTRANS_Outputstage == T_NONSEQ && HBURST_Outputstage == B_INCR) m_mode = 2;
         else if (HTRANS_Outputstage == T_NONSEQ && HBURST_Outputstage >= 3'd2) begin
            m_mode = 1;
            m_left = (1 << (int'(HBURST_Outputstage) / 2 + 1)) - 1;
         end else rearb = 1'b1;
      end else if (m_mode == 1) begin
         if (HTRANS_Outputstage == T_SEQ) begin
            m_left = m_left - 1;
            if (m_left <= 0) begin m_left = 0; m_mode = 0; end
         end else if (HTRANS_Outputstage != T_BUSY) begin
            m_left = 0; m_mode = 0;
         end
      end else begin
         if (HTRANS_Outputstage == T_IDLE || HTRANS_Outputstage == T_NONSEQ) m_mode = 0;
      end
`else
      rearb = (HTRANS_Outputstage == T_IDLE || HTRANS_Outputstage == T_NONSEQ);
`endif
      if (rearb) begin
         w = rr_pick(REQ, m_last);
         if (w >= 0) begin m_owner = w; m_last = w; m_idle = 1'b0; end
         else m_idle = !HSEL_Outputstage;
      end
   endtask

   // One bus cycle: drive, clock, update model, compare 1 time unit after the edge.
   task automatic step(input logic [3:0] req, input logic rdy, input logic hsel,
                       input logic [1:0] tr, input logic [2:0] hb, input logic lk);
      REQ = req; HREADY_Outputstage = rdy; HSEL_Outputstage = hsel;
      HTRANS_Outputstage = tr; HBURST_Outputstage = hb; HMASTLOCK_Outputstage = lk;
      @(posedge HCLK);
      model_step();
      #1;
      check_eq("model_sel", int'(PORT_SEL_ARBITER), m_owner);
      check_eq("model_nosel", int'(PORT_NOSEL_ARBITER), int'(m_idle));
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
   task automatic do_reset();
      HRESETn = 1'b0;
      #2;
      check_eq("rst_sel", int'(PORT_SEL_ARBITER), 0);
      check_eq("rst_nosel", int'(PORT_NOSEL_ARBITER), 1);
      model_reset();
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
   endtask

   initial begin
      logic [1:0] tr8 [11];
      logic       rd8 [11];
      HRESETn = 1'b0; REQ = 4'd0; HREADY_Outputstage = 1'b1; HSEL_Outputstage = 1'b0;
      HTRANS_Outputstage = T_IDLE; HBURST_Outputstage = B_SINGLE; HMASTLOCK_Outputstage = 1'b0;
      model_reset();
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      check_eq("reset_sel", int'(PORT_SEL_ARBITER), 0);
      check_eq("reset_nosel", int'(PORT_NOSEL_ARBITER), 1);

      step(4'b0000, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
      check_eq("noreq_nosel", int'(PORT_NOSEL_ARBITER), 1);
      step(4'b0101, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("rr0101_a", int'(PORT_SEL_ARBITER), 0);
      check_eq("rr0101_nosel", int'(PORT_NOSEL_ARBITER), 0);
      step(4'b0101, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("rr0101_b", int'(PORT_SEL_ARBITER), 2);
      step(4'b0101, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("rr0101_c", int'(PORT_SEL_ARBITER), 0);
      step(4'b0000, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("hsel_keep_sel", int'(PORT_SEL_ARBITER), 0);
      check_eq("hsel_keep_nosel", int'(PORT_NOSEL_ARBITER), 0);

      // SINGLE transfers with every port requesting rotate 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
         check_eq("rr_single", int'(PORT_SEL_ARBITER), i % 4);
      end

      // port 1 INCR4 with a BUSY beat
      do_reset();
      step(4'b1111, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      step(4'b1111, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("incr4_grant", int'(PORT_SEL_ARBITER), 1);
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, 1'b1, (i == 0) ? T_NONSEQ : ((i == 2) ? T_BUSY : T_SEQ), B_INCR4, 1'b0);
`ifdef AHB_ARB_BURST_LOCK_EN
         check_eq("incr4_hold", int'(PORT_SEL_ARBITER), 1);
`endif
      end
      step(4'b1111, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
`ifdef AHB_ARB_BURST_LOCK_EN
      check_eq("incr4_next", int'(PORT_SEL_ARBITER), 2);
`endif

      // INCR8 on port 1 with three stalled cycles in the middle
      do_reset();
      step(4'b0010, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("incr8_grant", int'(PORT_SEL_ARBITER), 1);
      tr8 = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
      rd8 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 11; i++) begin
         step(4'b1111, rd8[i], 1'b1, tr8[i], B_INCR8, 1'b0);
`ifdef AHB_ARB_BURST_LOCK_EN
         check_eq("incr8_hold", int'(PORT_SEL_ARBITER), 1);
`endif
      end
      step(4'b1111, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
`ifdef AHB_ARB_BURST_LOCK_EN
      check_eq("incr8_next", int'(PORT_SEL_ARBITER), 2);
`endif

      // locked INCR burst on port 3 while everybody else requests
      do_reset();
      step(4'b1000, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("lock_grant", int'(PORT_SEL_ARBITER), 3);
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, 1'b1, (i == 0) ? T_NONSEQ : ((i == 4) ? T_IDLE : T_SEQ), B_INCR, 1'b1);
         check_eq("lock_hold", int'(PORT_SEL_ARBITER), 3);
      end
      step(4'b1111, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("lock_release", int'(PORT_SEL_ARBITER), 0);

      // reset during beat 5 of a WRAP16 on port 2
      do_reset();
      step(4'b0100, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0);
      check_eq("wrap16_grant", int'(PORT_SEL_ARBITER), 2);
      step(4'b1111, 1'b1, 1'b1, T_NONSEQ, B_WRAP16, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b1, T_SEQ, B_WRAP16, 1'b0);
      do_reset();
      step(4'b0000, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
      check_eq("post_rst_nosel", int'(PORT_NOSEL_ARBITER), 1);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         step(4'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom),
              2'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
